// File: rtl/i2c_target.sv
// I2C target (responder) with a byte-wide register-file port.
// Oversamples SCL/SDA on clk (SCL must be <= clk/16). The first byte written
// after the address loads an 8-bit register pointer; later bytes are written
// to, or read from, the pointer, which auto-increments with 8-bit wrap.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   scl          bus clock, sampled only
//   sda          bus data, pulled low or released, never driven high
//   reg_addr     current register pointer
//   reg_wdata    write data, valid while reg_wr=1
//   reg_wr       one-clk write strobe
//   reg_rd       one-clk read request for reg_addr
//   reg_rdata    read data, valid on the clk after reg_rd
//   busy         high from an addressed START until STOP
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  tri1        scl,
  inout  tri1        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  // Synchroniser depth is clamped to the metastability-safe minimum.
  localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_REQ,
    RD_LOAD,
    RD_BYTE,
    RD_ACK,
    HOLD
  } state_t;

  logic [SYNC_W-1:0] scl_sync;
  logic [SYNC_W-1:0] sda_sync;
  logic              scl_q;
  logic              sda_q;
  logic              scl_s;
  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [7:0]        shift, shift_n;
  logic              first_byte, first_byte_n;
  logic              rw, rw_n;
  logic              sda_oe, sda_oe_n;
  logic [7:0]        reg_addr_n;
  logic [7:0]        reg_wdata_n;
  logic              reg_wr_n;
  logic              reg_rd_n;
  logic              busy_n;

  // Open-drain data output; SCL is never driven.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Input synchronisers plus one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_W-2:0], scl};
      sda_sync <= {sda_sync[SYNC_W-2:0], sda};
      scl_q    <= scl_sync[SYNC_W-1];
      sda_q    <= sda_sync[SYNC_W-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_W-1];
  assign sda_s     = sda_sync[SYNC_W-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      first_byte <= 1'b0;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      first_byte <= first_byte_n;
      rw         <= rw_n;
      sda_oe     <= sda_oe_n;
      reg_addr   <= reg_addr_n;
      reg_wdata  <= reg_wdata_n;
      reg_wr     <= reg_wr_n;
      reg_rd     <= reg_rd_n;
      busy       <= busy_n;
    end
  end

  // Next-state and output logic. START/STOP override every state.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    first_byte_n = first_byte;
    rw_n         = rw;
    sda_oe_n     = sda_oe;
    // Pointer advances on the clk after each write strobe.
    reg_addr_n   = reg_wr ? 8'(reg_addr + 8'd1) : reg_addr;
    reg_wdata_n  = reg_wdata;
    reg_wr_n     = 1'b0;
    reg_rd_n     = 1'b0;
    busy_n       = busy;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          sda_oe_n = 1'b0;
        end

        ADDR: begin
          if (scl_rise && bit_cnt < CNT_W'(8)) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
          end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
            if (shift[7:1] == TARGET_ADDR) begin
              sda_oe_n = 1'b1;
              rw_n     = shift[0];
              busy_n   = 1'b1;
              state_n  = ADDR_ACK;
            end else begin
              state_n  = IDLE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (rw) begin
              reg_rd_n = 1'b1;
              state_n  = RD_REQ;
            end else begin
              first_byte_n = 1'b1;
              state_n      = WR_BYTE;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise && bit_cnt < CNT_W'(8)) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              if (first_byte) begin
                reg_addr_n   = {shift[6:0], sda_s};
                first_byte_n = 1'b0;
              end else begin
                reg_wdata_n = {shift[6:0], sda_s};
                reg_wr_n    = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
            sda_oe_n = 1'b1;
            state_n  = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WR_BYTE;
          end
        end

        // reg_rd is high during this clk; data is taken one clk later so
        // both combinational and registered register files are supported.
        RD_REQ: begin
          state_n = RD_LOAD;
        end

        RD_LOAD: begin
          shift_n   = reg_rdata;
          sda_oe_n  = ~reg_rdata[7];
          bit_cnt_n = '0;
          state_n   = RD_BYTE;
        end

        // bit_cnt counts bits already presented; bit 7 went out on load.
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == CNT_W'(7)) begin
              sda_oe_n = 1'b0;
              state_n  = RD_ACK;
            end else begin
              bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
              shift_n   = {shift[6:0], 1'b0};
              sda_oe_n  = ~shift[6];
            end
          end
        end

        // bit_cnt==8 marks a master ACK seen, awaiting the closing fall.
        RD_ACK: begin
          sda_oe_n = 1'b0;
          if (scl_rise) begin
            if (!sda_s) begin
              reg_addr_n = 8'(reg_addr + 8'd1);
              bit_cnt_n  = CNT_W'(8);
            end else begin
              state_n    = HOLD;
            end
          end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
            reg_rd_n = 1'b1;
            state_n  = RD_REQ;
          end
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged bus master, register-file responder,
// scoreboard queues checked by a monitor on the register port.
module tb_i2c_target;

  localparam int unsigned Q = 5;
  localparam logic [6:0]  TADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst;
  tri1        scl_w;
  tri1        sda_w;
  logic       m_scl_low;
  logic       m_sda_low;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  assign scl_w = m_scl_low ? 1'b0 : 1'bz;
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;

  i2c_target #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_w),
    .sda       (sda_w),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] dev_mem[256];
  logic [7:0] ref_mem[256];
  logic       watch_pull = 1'b0;
  logic       saw_pull   = 1'b0;
  logic       watch_busy = 1'b0;
  logic       saw_busy   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register file the target talks to; read data is registered.
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= dev_mem[reg_addr];
    if (reg_wr) dev_mem[reg_addr] <= reg_wdata;
  end

  // Monitor: pops expectations whenever the register port strobes.
  always @(negedge clk) begin : mon
    wr_t        e;
    logic [7:0] ea;
    if (!rst) begin
      if (reg_wr && reg_rd) begin
        checks++; errors++;
        $display("FAIL wr_rd_same_clk: got reg_wr=1 reg_rd=1 expected exclusive");
      end
      if (reg_wr) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h expected no write", reg_addr, reg_wdata);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(e.addr));
          check("wr_data", 32'(reg_wdata), 32'(e.data));
        end
      end
      if (reg_rd) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd: got addr 0x%0h expected no read", reg_addr);
        end else begin
          ea = exp_rd_q.pop_front();
          check("rd_addr", 32'(reg_addr), 32'(ea));
        end
      end
      if (watch_pull && sda_w == 1'b0 && !m_sda_low) saw_pull = 1'b1;
      if (watch_busy && busy) saw_busy = 1'b1;
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // START from idle or repeated START from SCL low.
  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  // One bit, SCL low on entry and exit; returns SDA sampled mid-high.
  task automatic bus_bit(input logic b, output logic s);
    m_sda_low = ~b; wait_q();
    m_scl_low = 1'b0; wait_q();
    s = sda_w;      wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~send_ack, s);
  endtask

  // Model: n data bytes land at ptr, ptr+1, ... (mod 256); pointer ends at ptr+n.
  task automatic do_write(input logic [7:0] ptr, input logic [7:0] data[$]);
    logic       ack;
    logic [7:0] a;
    bus_start();
    write_byte({TADDR, 1'b0}, ack);
    check("w_addr_ack", 32'(ack), 0);
    check("w_busy", 32'(busy), 1);
    write_byte(ptr, ack);
    check("w_ptr_ack", 32'(ack), 0);
    for (int i = 0; i < data.size(); i++) begin
      a = 8'(ptr + 8'(i));
      exp_wr_q.push_back('{addr: a, data: data[i]});
      ref_mem[a] = data[i];
      write_byte(data[i], ack);
      check("w_data_ack", 32'(ack), 0);
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check("w_busy_after_stop", 32'(busy), 0);
    check("w_final_ptr", 32'(reg_addr), 32'(8'(ptr + 8'(data.size()))));
    check("w_queue_drained", 32'(exp_wr_q.size()), 0);
    check("w_sda_released", 32'(sda_w), 1);
  endtask

  // Model: n bytes read from ref_mem at ptr.. (mod 256), last one NACKed.
  task automatic do_read(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] d;
    logic [7:0] a;
    bus_start();
    write_byte({TADDR, 1'b0}, ack);
    check("r_waddr_ack", 32'(ack), 0);
    write_byte(ptr, ack);
    check("r_ptr_ack", 32'(ack), 0);
    bus_start();
    exp_rd_q.push_back(ptr);
    write_byte({TADDR, 1'b1}, ack);
    check("r_raddr_ack", 32'(ack), 0);
    for (int i = 0; i < n; i++) begin
      a = 8'(ptr + 8'(i));
      if (i < n - 1) exp_rd_q.push_back(8'(a + 8'd1));
      read_byte(i < n - 1, d);
      check("r_data", 32'(d), 32'(ref_mem[a]));
    end
    check("r_sda_after_nack", 32'(sda_w), 1);
    check("r_busy_before_stop", 32'(busy), 1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("r_busy_after_stop", 32'(busy), 0);
    check("r_final_ptr", 32'(reg_addr), 32'(8'(ptr + 8'(n - 1))));
    check("r_queue_drained", 32'(exp_rd_q.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic       ack;
    logic       s;
    logic [7:0] q[$];
    logic [7:0] ptr;
    int         n;

    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[8'h20] = 8'h5A; ref_mem[8'h20] = 8'h5A;
    dev_mem[8'h21] = 8'hC3; ref_mem[8'h21] = 8'hC3;
    dev_mem[8'h30] = 8'h35; ref_mem[8'h30] = 8'h35;

    rst = 1'b1; m_scl_low = 1'b0; m_sda_low = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_reg_addr", 32'(reg_addr), 0);
    check("rst_reg_wdata", 32'(reg_wdata), 0);
    check("rst_reg_wr", 32'(reg_wr), 0);
    check("rst_reg_rd", 32'(reg_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sda", 32'(sda_w), 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Addressed write.
    q = '{8'hA5, 8'h3C};
    do_write(8'h10, q);

    // Random read with repeated START.
    do_read(8'h20, 2);

    // Address mismatch: no pull, no strobes, busy stays low.
    watch_pull = 1'b1; saw_pull = 1'b0; watch_busy = 1'b1; saw_busy = 1'b0;
    bus_start();
    write_byte({7'h51, 1'b0}, ack);
    check("mm_addr_nack", 32'(ack), 1);
    write_byte(8'h00, ack);
    check("mm_data_nack", 32'(ack), 1);
    bus_stop();
    repeat (4) @(negedge clk);
    watch_pull = 1'b0; watch_busy = 1'b0;
    check("mm_sda_never_pulled", 32'(saw_pull), 0);
    check("mm_busy_never_high", 32'(saw_busy), 0);

    // Pointer wrap.
    q = '{8'h01, 8'h02};
    do_write(8'hFF, q);

    // Reset while the target drives a 0 data bit.
    exp_rd_q.push_back(8'h30);
    bus_start();
    write_byte({TADDR, 1'b0}, ack);
    write_byte(8'h30, ack);
    bus_start();
    write_byte({TADDR, 1'b1}, ack);
    check("rr_raddr_ack", 32'(ack), 0);
    wait_q();
    check("rr_target_pulls", 32'(sda_w), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rr_sda_released", 32'(sda_w), 1);
    check("rr_busy", 32'(busy), 0);
    check("rr_reg_addr", 32'(reg_addr), 0);
    check("rr_rd_drained", 32'(exp_rd_q.size()), 0);
    rst = 1'b0;
    m_scl_low = 1'b0;
    repeat (2 * Q) @(negedge clk);
    q = '{8'($urandom)};
    do_write(8'h44, q);

    // STOP after 4 bits of a data byte.
    bus_start();
    write_byte({TADDR, 1'b0}, ack);
    write_byte(8'h40, ack);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
    bus_stop();
    repeat (4) @(negedge clk);
    check("sib_busy", 32'(busy), 0);
    check("sib_sda", 32'(sda_w), 1);
    check("sib_ptr", 32'(reg_addr), 32'h40);
    // Without a START the target must stay silent.
    m_scl_low = 1'b1; wait_q();
    write_byte(8'h55, ack);
    check("sib_idle_no_ack", 32'(ack), 1);
    m_scl_low = 1'b0;
    repeat (2 * Q) @(negedge clk);

    // Randomised write-then-readback.
    for (int t = 0; t < 6; t++) begin
      ptr = 8'($urandom);
      n   = int'($urandom_range(1, 3));
      q   = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      do_write(ptr, q);
      do_read(ptr, n);
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
